// File: rtl/bus_width_splitter_if.sv
// Handshake bundle between the wide upstream port, the narrow downstream port
// and the splitter core. The master side issues wide requests and answers narrow beats.
interface bus_width_splitter_if #(
  parameter int AW       = 32,
  parameter int WideDW   = 64,
  parameter int NarrowDW = 32,
  parameter int SrcW     = 8
);
  localparam int WBW = WideDW / 8;
  localparam int NBW = NarrowDW / 8;

  logic                req_valid;
  logic                req_ready;
  logic [AW-1:0]       req_addr;
  logic                req_we;
  logic [WideDW-1:0]   req_wdata;
  logic [WBW-1:0]      req_be;
  logic [SrcW-1:0]     req_source;

  logic                nreq_valid;
  logic                nreq_ready;
  logic [AW-1:0]       nreq_addr;
  logic                nreq_we;
  logic [NarrowDW-1:0] nreq_wdata;
  logic [NBW-1:0]      nreq_be;

  logic                nrsp_valid;
  logic [NarrowDW-1:0] nrsp_rdata;
  logic                nrsp_error;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [WideDW-1:0]   rsp_rdata;
  logic                rsp_error;
  logic [SrcW-1:0]     rsp_source;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_be, req_source,
    output nreq_ready, nrsp_valid, nrsp_rdata, nrsp_error, rsp_ready,
    input  req_ready, nreq_valid, nreq_addr, nreq_we, nreq_wdata, nreq_be,
    input  rsp_valid, rsp_rdata, rsp_error, rsp_source
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_be, req_source,
    input  nreq_ready, nrsp_valid, nrsp_rdata, nrsp_error, rsp_ready,
    output req_ready, nreq_valid, nreq_addr, nreq_we, nreq_wdata, nreq_be,
    output rsp_valid, rsp_rdata, rsp_error, rsp_source
  );
endinterface

// File: rtl/bus_width_splitter.sv
// Splits one wide transaction into sequential narrow beats, skipping lanes with no
// byte enables, and reassembles read data and error into a single wide response.
module bus_width_splitter_core #(
  parameter int AW       = 32,
  parameter int WideDW   = 64,
  parameter int NarrowDW = 32,
  parameter int SrcW     = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  bus_width_splitter_if.slave bus
);
  localparam int RATIO   = WideDW / NarrowDW;
  localparam int WBW     = WideDW / 8;
  localparam int NBW     = NarrowDW / 8;
  localparam int BW      = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int LOG_WBW = $clog2(WBW);
  localparam int LOG_NBW = $clog2(NBW);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q;
  logic [AW-1:0]       addr_q;
  logic                we_q;
  logic [WideDW-1:0]   wdata_q;
  logic [WBW-1:0]      be_q;
  logic [SrcW-1:0]     source_q;
  logic [WideDW-1:0]   rdata_q;
  logic                error_q;
  logic [BW-1:0]       beat_q;

  // Lowest beat index >= from whose byte-enable slice is non-zero; RATIO if none.
  function automatic int find_beat(input logic [WBW-1:0] be, input int from);
    int idx;
    idx = RATIO;
    for (int k = RATIO - 1; k >= 0; k--) begin
      if (k >= from && |be[k*NBW +: NBW]) idx = k;
    end
    return idx;
  endfunction

  int first_d;
  int next_d;

  // NOTE: give every always_comb output a value on every path, or a latch is inferred.
  always_comb begin
    first_d = find_beat(bus.req_be, 0);
    next_d  = find_beat(be_q, int'(beat_q) + 1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      source_q <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
      beat_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          addr_q   <= bus.req_addr;
          we_q     <= bus.req_we;
          wdata_q  <= bus.req_wdata;
          be_q     <= bus.req_be;
          source_q <= bus.req_source;
          rdata_q  <= '0;
          error_q  <= 1'b0;
          // Skipped lanes are resolved here so a disabled beat never costs a cycle.
          if (first_d == RATIO) begin
            beat_q  <= '0;
            state_q <= RESP;
          end else begin
            beat_q  <= BW'(first_d);
            state_q <= ISSUE;
          end
        end
        ISSUE: if (bus.nreq_ready) state_q <= WAIT;
        WAIT: if (bus.nrsp_valid) begin
          if (!we_q) rdata_q[beat_q*NarrowDW +: NarrowDW] <= bus.nrsp_rdata;
          error_q <= error_q | bus.nrsp_error;
          if (next_d == RATIO) begin
            state_q <= RESP;
          end else begin
            beat_q  <= BW'(next_d);
            state_q <= ISSUE;
          end
        end
        RESP: if (bus.rsp_ready) begin
          beat_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.nreq_valid = (state_q == ISSUE);
  assign bus.nreq_addr  = {addr_q[AW-1:LOG_WBW], {LOG_WBW{1'b0}}} + (AW'(beat_q) << LOG_NBW);
  assign bus.nreq_we    = we_q;
  assign bus.nreq_wdata = wdata_q[beat_q*NarrowDW +: NarrowDW];
  assign bus.nreq_be    = be_q[beat_q*NBW +: NBW];
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_error  = error_q;
  assign bus.rsp_source = source_q;
endmodule

module bus_width_splitter #(
  parameter int AW       = 32,
  parameter int WideDW   = 64,
  parameter int NarrowDW = 32,
  parameter int SrcW     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AW-1:0]         req_addr_i,
  input  logic                  req_we_i,
  input  logic [WideDW-1:0]     req_wdata_i,
  input  logic [WideDW/8-1:0]   req_be_i,
  input  logic [SrcW-1:0]       req_source_i,
  output logic                  nreq_valid_o,
  input  logic                  nreq_ready_i,
  output logic [AW-1:0]         nreq_addr_o,
  output logic                  nreq_we_o,
  output logic [NarrowDW-1:0]   nreq_wdata_o,
  output logic [NarrowDW/8-1:0] nreq_be_o,
  input  logic                  nrsp_valid_i,
  input  logic [NarrowDW-1:0]   nrsp_rdata_i,
  input  logic                  nrsp_error_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WideDW-1:0]     rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic [SrcW-1:0]       rsp_source_o
);
  bus_width_splitter_if #(.AW(AW), .WideDW(WideDW), .NarrowDW(NarrowDW), .SrcW(SrcW)) bus_if ();

  assign bus_if.req_valid  = req_valid_i;
  assign bus_if.req_addr   = req_addr_i;
  assign bus_if.req_we     = req_we_i;
  assign bus_if.req_wdata  = req_wdata_i;
  assign bus_if.req_be     = req_be_i;
  assign bus_if.req_source = req_source_i;
  assign bus_if.nreq_ready = nreq_ready_i;
  assign bus_if.nrsp_valid = nrsp_valid_i;
  assign bus_if.nrsp_rdata = nrsp_rdata_i;
  assign bus_if.nrsp_error = nrsp_error_i;
  assign bus_if.rsp_ready  = rsp_ready_i;

  assign req_ready_o  = bus_if.req_ready;
  assign nreq_valid_o = bus_if.nreq_valid;
  assign nreq_addr_o  = bus_if.nreq_addr;
  assign nreq_we_o    = bus_if.nreq_we;
  assign nreq_wdata_o = bus_if.nreq_wdata;
  assign nreq_be_o    = bus_if.nreq_be;
  assign rsp_valid_o  = bus_if.rsp_valid;
  assign rsp_rdata_o  = bus_if.rsp_rdata;
  assign rsp_error_o  = bus_if.rsp_error;
  assign rsp_source_o = bus_if.rsp_source;

  bus_width_splitter_core #(.AW(AW), .WideDW(WideDW), .NarrowDW(NarrowDW), .SrcW(SrcW)) u_core (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );
endmodule

// File: tb/tb_bus_width_splitter.sv
// Scoreboard bench for bus_width_splitter at default widths (64-bit wide, 32-bit narrow).
// Expected beats and responses are queued when a request is driven and popped as the DUT emits them.
module tb_bus_width_splitter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_width_splitter_if #(.AW(32), .WideDW(64), .NarrowDW(32), .SrcW(8)) bus ();

  bus_width_splitter #(.AW(32), .WideDW(64), .NarrowDW(32), .SrcW(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (bus.req_valid),
    .req_ready_o  (bus.req_ready),
    .req_addr_i   (bus.req_addr),
    .req_we_i     (bus.req_we),
    .req_wdata_i  (bus.req_wdata),
    .req_be_i     (bus.req_be),
    .req_source_i (bus.req_source),
    .nreq_valid_o (bus.nreq_valid),
    .nreq_ready_i (bus.nreq_ready),
    .nreq_addr_o  (bus.nreq_addr),
    .nreq_we_o    (bus.nreq_we),
    .nreq_wdata_o (bus.nreq_wdata),
    .nreq_be_o    (bus.nreq_be),
    .nrsp_valid_i (bus.nrsp_valid),
    .nrsp_rdata_i (bus.nrsp_rdata),
    .nrsp_error_i (bus.nrsp_error),
    .rsp_valid_o  (bus.rsp_valid),
    .rsp_ready_i  (bus.rsp_ready),
    .rsp_rdata_o  (bus.rsp_rdata),
    .rsp_error_o  (bus.rsp_error),
    .rsp_source_o (bus.rsp_source)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lane;
  } beat_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic [7:0]  src;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_data(input logic [7:0] src, input int k);
    return 32'(32'h1111_1111 * (k + 1)) + {24'h0, src};
  endfunction

  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [63:0] wdata,
                         input logic [7:0] be, input logic [7:0] src, input logic [1:0] err_mask,
                         input int nstall, input int rstall, input bit chk_lat, input int exp_lat);
    rsp_t  er;
    beat_t eb;
    rsp_t  pr;
    int    t0;
    int    guard;
    bit    done;
    er.rdata = '0;
    er.err   = 1'b0;
    er.src   = src;
    for (int k = 0; k < 2; k++) begin
      if (be[k*4 +: 4] != 4'h0) begin
        eb.addr  = {addr[31:3], 3'b000} + 32'(k * 4);
        eb.we    = we;
        eb.wdata = wdata[k*32 +: 32];
        eb.be    = be[k*4 +: 4];
        eb.lane  = k;
        beat_q.push_back(eb);
        if (!we) er.rdata[k*32 +: 32] = lane_data(src, k);
        er.err = er.err | err_mask[k];
      end
    end
    rsp_q.push_back(er);

    check("req_ready_idle", {63'h0, bus.req_ready}, 64'h1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_we     = we;
    bus.req_wdata  = wdata;
    bus.req_be     = be;
    bus.req_source = src;
    t0 = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = '1;
    bus.req_be    = '1;

    done  = 1'b0;
    guard = 0;
    while (!done && guard < 200) begin
      guard++;
      check("req_ready_busy", {63'h0, bus.req_ready}, 64'h0);
      if (bus.rsp_valid) begin
        if (chk_lat) check("latency", 64'(cyc - t0), 64'(exp_lat));
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 64'h1, 64'h0);
        end else begin
          pr = rsp_q.pop_front();
          for (int s = 0; s <= rstall; s++) begin
            check("rsp_rdata", bus.rsp_rdata, pr.rdata);
            check("rsp_error", {63'h0, bus.rsp_error}, {63'h0, pr.err});
            check("rsp_source", {56'h0, bus.rsp_source}, {56'h0, pr.src});
            if (s < rstall) begin
              check("req_ready_resp", {63'h0, bus.req_ready}, 64'h0);
              @(negedge clk);
            end
          end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_valid_drop", {63'h0, bus.rsp_valid}, 64'h0);
        check("req_ready_back", {63'h0, bus.req_ready}, 64'h1);
        done = 1'b1;
      end else if (bus.nreq_valid) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat", 64'h1, 64'h0);
          bus.nreq_ready = 1'b1;
          @(negedge clk);
          bus.nreq_ready = 1'b0;
        end else begin
          eb = beat_q.pop_front();
          for (int s = 0; s <= nstall; s++) begin
            check("nreq_addr", {32'h0, bus.nreq_addr}, {32'h0, eb.addr});
            check("nreq_we", {63'h0, bus.nreq_we}, {63'h0, eb.we});
            check("nreq_wdata", {32'h0, bus.nreq_wdata}, {32'h0, eb.wdata});
            check("nreq_be", {60'h0, bus.nreq_be}, {60'h0, eb.be});
            if (s < nstall) begin
              // A stray response while the beat is still unaccepted must be ignored.
              bus.nrsp_valid = 1'b1;
              bus.nrsp_rdata = 32'hDEAD_BEEF;
              bus.nrsp_error = 1'b1;
              @(negedge clk);
              bus.nrsp_valid = 1'b0;
              bus.nrsp_error = 1'b0;
            end
          end
          bus.nreq_ready = 1'b1;
          @(negedge clk);
          bus.nreq_ready = 1'b0;
          check("nreq_valid_wait", {63'h0, bus.nreq_valid}, 64'h0);
          bus.nrsp_valid = 1'b1;
          bus.nrsp_rdata = lane_data(src, eb.lane);
          bus.nrsp_error = err_mask[eb.lane];
          @(negedge clk);
          bus.nrsp_valid = 1'b0;
          bus.nrsp_error = 1'b0;
          bus.nrsp_rdata = '0;
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("rsp_timeout", 64'h0, 64'h1);
    check("beats_left", 64'(beat_q.size()), 64'h0);
    beat_q.delete();
    rsp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {63'h0, bus.req_ready}, 64'h1);
    check({tag, "_nreq_valid"}, {63'h0, bus.nreq_valid}, 64'h0);
    check({tag, "_rsp_valid"}, {63'h0, bus.rsp_valid}, 64'h0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 64'h0);
    check({tag, "_rsp_error"}, {63'h0, bus.rsp_error}, 64'h0);
    check({tag, "_rsp_source"}, {56'h0, bus.rsp_source}, 64'h0);
    check({tag, "_nreq_addr"}, {32'h0, bus.nreq_addr}, 64'h0);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_we     = 1'b0;
    bus.req_wdata  = '0;
    bus.req_be     = '0;
    bus.req_source = '0;
    bus.nreq_ready = 1'b0;
    bus.nrsp_valid = 1'b0;
    bus.nrsp_rdata = '0;
    bus.nrsp_error = 1'b0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    run_txn(32'h0000_1004, 1'b0, 64'h0, 8'hFF, 8'h00, 2'b00, 0, 0, 1'b1, 5);
    run_txn(32'h0000_2000, 1'b1, 64'hAABBCCDD_00000000, 8'hF0, 8'h03, 2'b00, 0, 0, 1'b0, 0);
    run_txn(32'h0000_2000, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'h00, 8'h5A, 2'b00, 0, 0, 1'b1, 1);
    run_txn(32'h0000_3000, 1'b0, 64'h0, 8'hFF, 8'h21, 2'b01, 0, 0, 1'b1, 5);
    run_txn(32'h0000_4008, 1'b0, 64'h0, 8'hFF, 8'h77, 2'b00, 3, 2, 1'b0, 0);
    run_txn(32'h0000_0040, 1'b0, 64'h0, 8'h30, 8'h09, 2'b00, 0, 0, 1'b0, 0);
    run_txn(32'h0000_5000, 1'b0, 64'h0, 8'h01, 8'h0A, 2'b10, 0, 1, 1'b0, 0);
    run_txn(32'h0000_6004, 1'b1, 64'hCAFEF00D_0BADC0DE, 8'hFF, 8'h44, 2'b10, 1, 0, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      run_txn($urandom, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom),
              8'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 2),
              1'b0, 0);
    end

    // Reset while a read beat is outstanding.
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h0000_7000;
    bus.req_we     = 1'b0;
    bus.req_be     = 8'hFF;
    bus.req_source = 8'h66;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    check("rst_pre_issue", {63'h0, bus.nreq_valid}, 64'h1);
    bus.nreq_ready = 1'b1;
    @(negedge clk);
    bus.nreq_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.nrsp_valid = 1'b1;
    bus.nrsp_rdata = 32'h5555_AAAA;
    bus.nrsp_error = 1'b1;
    @(negedge clk);
    bus.nrsp_valid = 1'b0;
    bus.nrsp_error = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("post_rst_rsp_valid", {63'h0, bus.rsp_valid}, 64'h0);
      check("post_rst_nreq_valid", {63'h0, bus.nreq_valid}, 64'h0);
      @(negedge clk);
    end

    run_txn(32'h0000_8004, 1'b0, 64'h0, 8'hFF, 8'h12, 2'b00, 0, 0, 1'b1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
